// File: rtl/bram_tdp_pkg.sv
// Shared types and helpers for the BRAM true-dual-port requester slice.
// Holds the top-level state encoding and response FIFO sizing.
package bram_tdp_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int RSP_FIFO_DEPTH = 2;

   function automatic int depth(input int awidth);
      return 1 << awidth;
   endfunction

endpackage

// File: rtl/bram_tdp_rsp_fifo.sv
// Two-entry first-word-fall-through FIFO holding BRAM read responses.
// A pop on an empty FIFO is ignored; a push when full is only honoured alongside a pop.
module bram_tdp_rsp_fifo
   import bram_tdp_pkg::*;
#(
   parameter int DWIDTH = 36
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic [DWIDTH-1:0] head,
   output logic [1:0]        count,
   output logic              valid
);

   localparam logic [1:0] FULL = 2'(RSP_FIFO_DEPTH);

   logic [DWIDTH-1:0] mem_q [RSP_FIFO_DEPTH];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;
   logic              do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != FULL) || do_pop);
      wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
      count_d  = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign valid = (count_q != 2'd0);

endmodule

// File: rtl/bram_tdp_port_requester.sv
// Initiator for one port of a true-dual-port BRAM: valid/ready requests in,
// BRAM port strobes out, read data returned in order through a 2-entry FIFO.
module bram_tdp_port_requester
   import bram_tdp_pkg::*;
#(
   parameter int AWIDTH    = 10,
   parameter int DWIDTH    = 36,
   parameter int INIT_ZERO = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [AWIDTH-1:0] req_addr,
   input  logic [DWIDTH-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rce,
   output logic [AWIDTH-1:0] ra,
   input  logic [DWIDTH-1:0] rq,
   output logic              wce,
   output logic [AWIDTH-1:0] wa,
   output logic [DWIDTH-1:0] wd,
   output logic              init_done
);

   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(depth(AWIDTH) - 1);
   localparam state_t            RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;
   logic              inflight_q, inflight_d;
   logic [AWIDTH-1:0] ra_q, wa_q;
   logic [DWIDTH-1:0] wd_q;

   logic [1:0]        fifo_count;
   logic [2:0]        outstanding;
   logic              in_init, in_run;
   logic              acc_rd, acc_wr;

   // Outputs are forced to their reset values while rst is held.
   assign in_init     = !rst && (state_q == ST_INIT);
   assign in_run      = !rst && (state_q == ST_RUN);
   assign outstanding = {1'b0, fifo_count} + {2'b00, inflight_q};
   assign req_ready   = in_run && (outstanding < 3'd2);
   assign acc_rd      = req_valid && req_ready && !req_we;
   assign acc_wr      = req_valid && req_ready && req_we;
   assign init_done   = in_run;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      inflight_d = acc_rd;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST_ADDR) begin
            state_d = ST_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RST_STATE;
         cnt_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         inflight_q <= inflight_d;
      end
   end

   // Port drive: reads and writes are mutually exclusive by construction.
   always_comb begin
      rce = acc_rd;
      ra  = acc_rd ? req_addr : ra_q;
      wce = in_init || acc_wr;
      wa  = wa_q;
      wd  = wd_q;
      if (in_init) begin
         wa = cnt_q;
         wd = '0;
      end else if (acc_wr) begin
         wa = req_addr;
         wd = req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      ra_q <= ra;
      wa_q <= wa;
      wd_q <= wd;
   end

   // The BRAM returns rq one cycle after rce; inflight marks that cycle.
   bram_tdp_rsp_fifo #(
      .DWIDTH(DWIDTH)
   ) u_rsp_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (inflight_q),
      .push_data(rq),
      .pop      (rsp_ready),
      .head     (rsp_rdata),
      .count    (fifo_count),
      .valid    (rsp_valid)
   );

endmodule
